// File: rtl/qpsk_frame_sched.sv
// Two-requester round-robin frame scheduler for the QPSK serializer.
// para_o changes only on the serializer's frame boundary.
module qpsk_frame_sched #(
  parameter logic [13:0] DIV       = 14'd10000,
  parameter logic [39:0] IDLE_WORD = 40'hAAAAAAAAAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [39:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [39:0] req1_data,
  output logic        req1_ready,
  output logic [39:0] para_o,
  output logic        frame_start,
  output logic [1:0]  frame_src,
  output logic [15:0] tx_frame_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_st_t;

  buf_st_t     st0_q, st0_d;
  buf_st_t     st1_q, st1_d;
  logic [39:0] data0_q, data1_q;
  logic [13:0] div_cnt;
  logic [5:0]  bit_cnt;
  // 0: requester 0 served last, 1: requester 1
  logic        rr_last;

  logic div_end, bnd;
  logic full0, full1;
  logic grant0, grant1;

  assign div_end = (div_cnt == DIV - 14'd1);
  assign bnd     = div_end && (bit_cnt == 6'd39);
  assign full0   = (st0_q == FULL);
  assign full1   = (st1_q == FULL);

  assign req0_ready = ~full0;
  assign req1_ready = ~full1;

  // arbitration sees buffer state from before the boundary edge
  assign grant0 = bnd & full0 & (~full1 | rr_last);
  assign grant1 = bnd & full1 & (~full0 | ~rr_last);

  always_comb begin
    st0_d = st0_q;
    st1_d = st1_q;
    case (st0_q)
      EMPTY: if (req0_valid) st0_d = FULL;
      FULL:  if (grant0)     st0_d = EMPTY;
      default: st0_d = EMPTY;
    endcase
    case (st1_q)
      EMPTY: if (req1_valid) st1_d = FULL;
      FULL:  if (grant1)     st1_d = EMPTY;
      default: st1_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q   <= EMPTY;
      st1_q   <= EMPTY;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      st0_q <= st0_d;
      st1_q <= st1_d;
      if (req0_valid && !full0) data0_q <= req0_data;
      if (req1_valid && !full1) data1_q <= req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (div_end) begin
      div_cnt <= '0;
      bit_cnt <= (bit_cnt == 6'd39) ? 6'd0 : bit_cnt + 6'd1;
    end else begin
      div_cnt <= div_cnt + 14'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      para_o       <= IDLE_WORD;
      frame_start  <= 1'b0;
      frame_src    <= 2'd0;
      tx_frame_cnt <= '0;
      rr_last      <= 1'b1;
    end else begin
      frame_start <= bnd;
      if (grant0) begin
        para_o       <= data0_q;
        frame_src    <= 2'd1;
        rr_last      <= 1'b0;
        tx_frame_cnt <= tx_frame_cnt + 16'd1;
      end else if (grant1) begin
        para_o       <= data1_q;
        frame_src    <= 2'd2;
        rr_last      <= 1'b1;
        tx_frame_cnt <= tx_frame_cnt + 16'd1;
      end else if (bnd) begin
        para_o    <= IDLE_WORD;
        frame_src <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_frame_sched.sv
// Directed bench for qpsk_frame_sched with DIV=4 (160 clk per frame).
// Frame boundaries are tracked by counting clock edges since reset.
module tb_qpsk_frame_sched;

  localparam logic [39:0] IDLE = 40'hAAAAAAAAAA;
  localparam logic [39:0] D0   = 40'h123456789A;
  localparam logic [39:0] D1   = 40'hC35A5A0F0F;
  localparam logic [39:0] D2   = 40'h00FFFF0001;
  localparam logic [39:0] D3   = 40'h7EDCBA9876;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [39:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [39:0] req1_data = '0;
  logic        req1_ready;
  logic [39:0] para_o;
  logic        frame_start;
  logic [1:0]  frame_src;
  logic [15:0] tx_frame_cnt;

  int total = 0;
  int bad = 0;
  int edges = 0;

  qpsk_frame_sched #(
    .DIV(14'd4),
    .IDLE_WORD(IDLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .para_o(para_o),
    .frame_start(frame_start),
    .frame_src(frame_src),
    .tx_frame_cnt(tx_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // advance at least one edge, stopping in frame cycle p (0..159)
  task automatic to_pos(input int p);
    do tick(); while ((edges % 160) != p);
  endtask

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [39:0] p,
                           input logic [1:0] s, input logic [15:0] c);
    chk({tag, "_start"}, {39'd0, frame_start}, 40'd1);
    chk({tag, "_para"}, para_o, p);
    chk({tag, "_src"}, {38'd0, frame_src}, {38'd0, s});
    chk({tag, "_cnt"}, {24'd0, tx_frame_cnt}, {24'd0, c});
  endtask

  task automatic load(input logic v0, input logic [39:0] d0,
                      input logic v1, input logic [39:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_para", para_o, IDLE);
    chk("rst_start", {39'd0, frame_start}, 40'd0);
    chk("rst_src", {38'd0, frame_src}, 40'd0);
    chk("rst_cnt", {24'd0, tx_frame_cnt}, 40'd0);
    chk("rst_rdy0", {39'd0, req0_ready}, 40'd1);
    chk("rst_rdy1", {39'd0, req1_ready}, 40'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;

    // idle frames every 160 clk
    to_pos(159);
    chk("idle_nostart", {39'd0, frame_start}, 40'd0);
    tick();
    chk_frame("idle1", IDLE, 2'd0, 16'd0);
    tick();
    chk("idle_pulse_end", {39'd0, frame_start}, 40'd0);
    to_pos(0);
    chk_frame("idle2", IDLE, 2'd0, 16'd0);

    // single requester 0 frame
    to_pos(10);
    load(1'b1, D0, 1'b0, '0);
    chk("t2_rdy0_low", {39'd0, req0_ready}, 40'd0);
    to_pos(0);
    chk_frame("t2", D0, 2'd1, 16'd1);
    chk("t2_rdy0_back", {39'd0, req0_ready}, 40'd1);

    // both full, rr_last=req0 -> req1 first, then alternate
    load(1'b1, D1, 1'b1, D2);
    chk("t3_rdy0", {39'd0, req0_ready}, 40'd0);
    chk("t3_rdy1", {39'd0, req1_ready}, 40'd0);
    to_pos(0);
    chk_frame("t3a", D2, 2'd2, 16'd2);
    chk("t3a_rdy0", {39'd0, req0_ready}, 40'd0);
    chk("t3a_rdy1", {39'd0, req1_ready}, 40'd1);
    load(1'b0, '0, 1'b1, D3);
    to_pos(0);
    chk_frame("t3b", D1, 2'd1, 16'd3);
    to_pos(0);
    chk_frame("t3c", D3, 2'd2, 16'd4);

    // accept exactly in the boundary cycle is deferred one frame
    to_pos(159);
    chk("t4_rdy1_pre", {39'd0, req1_ready}, 40'd1);
    load(1'b0, '0, 1'b1, D0);
    chk_frame("t4a", IDLE, 2'd0, 16'd4);
    chk("t4_rdy1", {39'd0, req1_ready}, 40'd0);
    to_pos(0);
    chk_frame("t4b", D0, 2'd2, 16'd5);

    // frame counter wrap
    to_pos(5);
    force dut.tx_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.tx_frame_cnt;
    tick();
    chk("t5_forced", {24'd0, tx_frame_cnt}, 40'h00_0000_FFFF);
    load(1'b1, D2, 1'b0, '0);
    to_pos(0);
    chk_frame("t5", D2, 2'd1, 16'd0);

    // reset mid-frame with both buffers full
    load(1'b1, D1, 1'b1, D3);
    to_pos(80);
    rst_n = 1'b0;
    #3;
    chk("t6_para", para_o, IDLE);
    chk("t6_src", {38'd0, frame_src}, 40'd0);
    chk("t6_cnt", {24'd0, tx_frame_cnt}, 40'd0);
    chk("t6_start", {39'd0, frame_start}, 40'd0);
    chk("t6_rdy0", {39'd0, req0_ready}, 40'd1);
    chk("t6_rdy1", {39'd0, req1_ready}, 40'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    to_pos(0);
    chk_frame("t6_idle", IDLE, 2'd0, 16'd0);

    // rr_last back at req1 after reset -> req0 wins a tie
    load(1'b1, D3, 1'b1, D1);
    to_pos(0);
    chk_frame("t6_rr", D3, 2'd1, 16'd1);
    to_pos(0);
    chk_frame("t6_rr2", D1, 2'd2, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
